// File: rtl/pzcorebus_downsizer_request_arbiter_pkg.sv
// Shared types for the downsizer request arbiter: arbitration state and
// the width helper used to size requester-index types.
package pzcorebus_downsizer_request_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester-index type; never narrower than one bit.
  function automatic int requester_index_width(input int requesters);
    return (requesters > 1) ? $clog2(requesters) : 1;
  endfunction

endpackage

// File: rtl/pzcorebus_downsizer_grant_queue.sv
// In-order FIFO of requester indices whose write commands have been accepted
// but whose data bursts have not yet completed.
module pzcorebus_downsizer_grant_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_index,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (count == '0);
  assign o_full  = (count == (PW + 1)'(DEPTH));
  assign o_head  = entries[head_ptr];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (do_push) begin
        entries[tail_ptr] <= i_push_index;
        tail_ptr          <= next_ptr(tail_ptr);
      end
      if (do_pop) begin
        head_ptr <= next_ptr(head_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pzcorebus_downsizer_request_arbiter.sv
// Round-robin command arbiter in front of the downsizer; write data is steered
// to the owner of the oldest outstanding write command (or bypassed when idle).
module pzcorebus_downsizer_request_arbiter
  import pzcorebus_downsizer_request_arbiter_pkg::*;
#(
  parameter int REQUESTERS    = 4,
  parameter int COMMAND_WIDTH = 64,
  parameter int DATA_WIDTH    = 256,
  parameter int BYTEEN_WIDTH  = 32,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [REQUESTERS-1:0]               i_mcmd_valid,
  input  logic [REQUESTERS-1:0]               i_mcmd_with_data,
  input  logic [REQUESTERS*COMMAND_WIDTH-1:0] i_mcmd,
  output logic [REQUESTERS-1:0]               o_scmd_accept,
  input  logic [REQUESTERS-1:0]               i_mdata_valid,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_mdata,
  input  logic [REQUESTERS*BYTEEN_WIDTH-1:0]  i_mdata_byteen,
  input  logic [REQUESTERS-1:0]               i_mdata_last,
  output logic [REQUESTERS-1:0]               o_sdata_accept,
  output logic                                o_mcmd_valid,
  output logic [COMMAND_WIDTH-1:0]            o_mcmd,
  input  logic                                i_scmd_accept,
  output logic                                o_mdata_valid,
  output logic [DATA_WIDTH-1:0]               o_mdata,
  output logic [BYTEEN_WIDTH-1:0]             o_mdata_byteen,
  output logic                                o_mdata_last,
  input  logic                                i_sdata_accept
);
  localparam int IW = requester_index_width(REQUESTERS);
  typedef logic [IW-1:0] index_t;

  arb_state_e            state;
  arb_state_e            state_next;
  index_t                pointer;
  index_t                lock_grant;
  index_t                grant;
  logic [IW:0]           rr_result;
  logic [REQUESTERS-1:0] eligible;
  logic                  cmd_ack;
  logic                  with_data_ack;
  logic                  q_empty;
  logic                  q_full;
  index_t                q_head;
  index_t                owner;
  logic                  has_owner;
  logic                  bypass;
  logic                  data_last_ack;
  logic                  push;
  logic                  pop;

  // Returns {found, index} of the first set request at or after ptr.
  function automatic logic [IW:0] rr_priority(input logic [REQUESTERS-1:0] req,
                                              input index_t ptr);
    logic [IW:0] result;
    int          idx;
    result = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % REQUESTERS;
      if (req[idx]) result = {1'b1, index_t'(idx)};
    end
    return result;
  endfunction

  // A full queue cannot take another write, so writes sit out arbitration.
  assign eligible  = i_mcmd_valid & ~(i_mcmd_with_data & {REQUESTERS{q_full}});
  assign rr_result = rr_priority(eligible, pointer);

  // Handshake: a beat transfers when valid and accept are both high in the
  // same cycle; a presented command is held (locked) until that happens.
  always_comb begin
    state_next    = state;
    grant         = rr_result[IW-1:0];
    o_mcmd_valid  = rr_result[IW];
    o_scmd_accept = '0;
    if (state == ARB_LOCKED) begin
      grant        = lock_grant;
      o_mcmd_valid = 1'b1;
    end
    cmd_ack = o_mcmd_valid & i_scmd_accept;
    if (cmd_ack) o_scmd_accept[grant] = 1'b1;
    if (o_mcmd_valid && !i_scmd_accept) state_next = ARB_LOCKED;
    else if (cmd_ack)                   state_next = ARB_IDLE;
  end

  assign o_mcmd = i_mcmd[int'(grant)*COMMAND_WIDTH +: COMMAND_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ARB_IDLE;
      pointer    <= '0;
      lock_grant <= '0;
    end else begin
      state <= state_next;
      if (state_next == ARB_LOCKED) lock_grant <= grant;
      if (cmd_ack) pointer <= (grant == index_t'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
    end
  end

  // A write accepted while the queue is empty owns the data path at once.
  assign with_data_ack = cmd_ack & i_mcmd_with_data[grant];
  assign bypass        = q_empty & with_data_ack;
  assign has_owner     = ~q_empty | with_data_ack;
  assign owner         = q_empty ? grant : q_head;

  always_comb begin
    o_mdata_valid  = 1'b0;
    o_mdata        = '0;
    o_mdata_byteen = '0;
    o_mdata_last   = 1'b0;
    o_sdata_accept = '0;
    if (has_owner) begin
      o_mdata_valid          = i_mdata_valid[owner];
      o_mdata                = i_mdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      o_mdata_byteen         = i_mdata_byteen[int'(owner)*BYTEEN_WIDTH +: BYTEEN_WIDTH];
      o_mdata_last           = i_mdata_last[owner];
      o_sdata_accept[owner]  = i_sdata_accept;
    end
  end

  assign data_last_ack = o_mdata_valid & i_sdata_accept & o_mdata_last;
  assign pop           = ~q_empty & data_last_ack;
  assign push          = with_data_ack & ~(bypass & data_last_ack);

  pzcorebus_downsizer_grant_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (IW)
  ) u_grant_queue (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (push),
    .i_push_index (grant),
    .i_pop        (pop),
    .o_head       (q_head),
    .o_empty      (q_empty),
    .o_full       (q_full)
  );

endmodule

// File: tb/tb_pzcorebus_downsizer_request_arbiter.sv
// Bench for the downsizer request arbiter: directed scenarios plus random
// traffic, each cycle compared against a queue-based reference model.
module tb_pzcorebus_downsizer_request_arbiter;
  localparam int R  = 4;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int QD = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [R-1:0]    mcmd_valid, mcmd_with_data, mdata_valid, mdata_last;
  logic [R*CW-1:0] mcmd;
  logic [R*DW-1:0] mdata;
  logic [R*BW-1:0] mdata_byteen;
  logic            scmd_accept, sdata_accept;
  logic [R-1:0]    o_scmd_accept, o_sdata_accept;
  logic            o_mcmd_valid, o_mdata_valid, o_mdata_last;
  logic [CW-1:0]   o_mcmd;
  logic [DW-1:0]   o_mdata;
  logic [BW-1:0]   o_mdata_byteen;

  // Reference model state.
  int              m_ptr;
  int              m_held;
  logic [1:0]      exp_q[$];
  logic [R-1:0]    m_cmd_acc;
  logic [R-1:0]    m_data_last_acc;

  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  pzcorebus_downsizer_request_arbiter #(
    .REQUESTERS (R), .COMMAND_WIDTH (CW), .DATA_WIDTH (DW),
    .BYTEEN_WIDTH (BW), .QUEUE_DEPTH (QD)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_mcmd_valid (mcmd_valid), .i_mcmd_with_data (mcmd_with_data), .i_mcmd (mcmd),
    .o_scmd_accept (o_scmd_accept),
    .i_mdata_valid (mdata_valid), .i_mdata (mdata), .i_mdata_byteen (mdata_byteen),
    .i_mdata_last (mdata_last), .o_sdata_accept (o_sdata_accept),
    .o_mcmd_valid (o_mcmd_valid), .o_mcmd (o_mcmd), .i_scmd_accept (scmd_accept),
    .o_mdata_valid (o_mdata_valid), .o_mdata (o_mdata), .o_mdata_byteen (o_mdata_byteen),
    .o_mdata_last (o_mdata_last), .i_sdata_accept (sdata_accept)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clear_inputs();
    mcmd_valid = '0; mcmd_with_data = '0; mcmd = '0;
    mdata_valid = '0; mdata_last = '0; mdata = '0; mdata_byteen = '0;
    scmd_accept = 1'b0; sdata_accept = 1'b0;
  endtask

  task automatic set_cmd(input int r, input logic v, input logic wd);
    mcmd_valid[r]         = v;
    mcmd_with_data[r]     = wd;
    mcmd[r*CW +: CW]      = CW'($urandom);
  endtask

  task automatic set_data(input int r, input logic v, input logic last);
    mdata_valid[r]        = v;
    mdata_last[r]         = last;
    mdata[r*DW +: DW]     = DW'($urandom);
    mdata_byteen[r*BW +: BW] = BW'($urandom);
  endtask

  // Called at a negedge with inputs already driven; checks outputs, then
  // advances the model across the next posedge and returns at the next negedge.
  task automatic cycle();
    int   g, r, owner;
    logic found, ack, dlast, exp_mvalid, bypass;
    #1;
    found = 1'b0; g = 0;
    if (m_held >= 0) begin
      found = 1'b1; g = m_held;
    end else begin
      for (int k = 0; k < R; k++) begin
        r = (m_ptr + k) % R;
        if (!found && mcmd_valid[r] && !(mcmd_with_data[r] && exp_q.size() == QD)) begin
          found = 1'b1; g = r;
        end
      end
    end
    ack = found && scmd_accept;
    check("mcmd_valid", 64'(o_mcmd_valid), 64'(found));
    if (found) check("mcmd", 64'(o_mcmd), 64'(mcmd[g*CW +: CW]));
    check("scmd_accept", 64'(o_scmd_accept), ack ? (64'd1 << g) : 64'd0);

    if (exp_q.size() > 0)              owner = int'(exp_q[0]);
    else if (ack && mcmd_with_data[g]) owner = g;
    else                               owner = -1;
    exp_mvalid = (owner >= 0) && mdata_valid[owner];
    check("mdata_valid", 64'(o_mdata_valid), 64'(exp_mvalid));
    if (owner >= 0) begin
      check("mdata", 64'(o_mdata), 64'(mdata[owner*DW +: DW]));
      check("mdata_byteen", 64'(o_mdata_byteen), 64'(mdata_byteen[owner*BW +: BW]));
      check("mdata_last", 64'(o_mdata_last), 64'(mdata_last[owner]));
      check("sdata_accept", 64'(o_sdata_accept), sdata_accept ? (64'd1 << owner) : 64'd0);
    end else begin
      check("sdata_accept_idle", 64'(o_sdata_accept), 64'd0);
    end
    dlast = exp_mvalid && sdata_accept && mdata_last[owner];

    @(posedge clk);
    m_cmd_acc = '0; m_data_last_acc = '0;
    if (found && !scmd_accept) m_held = g;
    if (ack) begin
      m_held = -1;
      m_ptr  = (g + 1) % R;
      m_cmd_acc[g] = 1'b1;
    end
    if (dlast) m_data_last_acc[owner] = 1'b1;
    bypass = (exp_q.size() == 0) && (owner >= 0);
    if (!bypass && dlast) void'(exp_q.pop_front());
    if (ack && mcmd_with_data[g] && !(bypass && dlast)) exp_q.push_back(2'(g));
    @(negedge clk);
  endtask

  // Drop the commands and finished bursts the model says were taken.
  task automatic retire();
    for (int i = 0; i < R; i++) begin
      if (m_cmd_acc[i]) mcmd_valid[i] = 1'b0;
      if (m_data_last_acc[i]) mdata_valid[i] = 1'b0;
    end
  endtask

  // Asserts reset mid low-phase with whatever inputs are currently driven.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mcmd_valid", 64'(o_mcmd_valid), 64'd0);
    check("rst_scmd_accept", 64'(o_scmd_accept), 64'd0);
    check("rst_mdata_valid", 64'(o_mdata_valid), 64'd0);
    check("rst_sdata_accept", 64'(o_sdata_accept), 64'd0);
    m_ptr = 0; m_held = -1; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    m_ptr = 0; m_held = -1;
    @(negedge clk);
    apply_reset();

    // Two reads together from pointer 0: req0 then req2, pointer lands on 3.
    scmd_accept = 1'b1;
    set_cmd(0, 1, 0); set_cmd(2, 1, 0);
    cycle(); check("t2_first_req0", 64'(m_cmd_acc), 64'b0001); retire();
    cycle(); check("t2_then_req2", 64'(m_cmd_acc), 64'b0100); retire();
    check("t2_pointer", 64'(m_ptr), 64'd3);
    for (int i = 0; i < R; i++) set_cmd(i, 1, 0);
    cycle(); retire();
    clear_inputs();

    // Write from req1 stalled 3 cycles while req0 arrives: grant held.
    apply_reset();
    set_cmd(1, 1, 1);
    cycle();
    set_cmd(0, 1, 0);
    cycle(); cycle();
    scmd_accept = 1'b1;
    cycle(); check("t3_locked_req1", 64'(m_cmd_acc), 64'b0010); retire();
    set_data(1, 1, 1); sdata_accept = 1'b1;
    cycle(); retire();
    cycle(); retire();
    clear_inputs();

    // Bypass: write cmd and first beat together on an empty queue, 4 beats.
    apply_reset();
    scmd_accept = 1'b1; sdata_accept = 1'b1;
    set_cmd(2, 1, 1); set_data(2, 1, 0);
    cycle(); retire();
    for (int b = 1; b < 4; b++) begin
      set_data(2, 1, b == 3);
      cycle(); retire();
    end
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    set_data(1, 1, 1);
    cycle();
    clear_inputs();

    // Queue depth 2 with data stalled: third write masked, read still passes.
    apply_reset();
    scmd_accept = 1'b1;
    set_cmd(3, 1, 1); set_data(3, 1, 1); cycle(); retire();
    set_cmd(1, 1, 1); set_data(1, 1, 1); cycle(); retire();
    set_cmd(2, 1, 1); set_data(2, 1, 1); set_cmd(0, 1, 0);
    cycle(); check("t5_read_passes", 64'(m_cmd_acc), 64'b0001); retire();
    cycle(); check("t5_write_masked", 64'(m_cmd_acc), 64'b0000); retire();
    sdata_accept = 1'b1;
    cycle(); check("t5_data_req3", 64'(m_data_last_acc), 64'b1000);
             check("t5_masked_on_pop", 64'(m_cmd_acc), 64'b0000); retire();
    cycle(); check("t5_data_req1", 64'(m_data_last_acc), 64'b0010); retire();
    cycle(); check("t5_data_req2", 64'(m_data_last_acc), 64'b0100); retire();
    clear_inputs();

    // Reset during beat 2 of 4, then a fresh bypassed write from req1.
    apply_reset();
    scmd_accept = 1'b1; sdata_accept = 1'b1;
    set_cmd(0, 1, 1); set_data(0, 1, 0);
    cycle(); retire();
    set_data(0, 1, 0);
    apply_reset();
    clear_inputs();
    scmd_accept = 1'b1; sdata_accept = 1'b1;
    set_cmd(1, 1, 1); set_data(1, 1, 1);
    cycle(); check("t6_bypass_after_reset", 64'(m_data_last_acc), 64'b0010); retire();
    clear_inputs();

    // Random traffic: commands held until taken, data free-running.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!mcmd_valid[i] && $urandom_range(0, 2) == 0) set_cmd(i, 1, 1'($urandom));
        set_data(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      end
      scmd_accept  = 1'($urandom_range(0, 3) != 0);
      sdata_accept = 1'($urandom_range(0, 3) != 0);
      cycle(); retire();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
